// File: rtl/mem_access_stage.sv
// Memory stage of the multi-cycle MIPS datapath: resolves the branch, runs lw/sw over req/ack.
// Define MEM_TIMEOUT_EN to abort a request that is not acknowledged within TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        stage,
    input  logic [31:0]       alu_result,
    input  logic              zero,
    input  logic [31:0]       branch_value,
    input  logic [31:0]       store_data,
    input  logic [31:0]       pc_plus4,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [31:0]       mem_data,
    output logic [31:0]       branch_target,
    output logic              pc_src,
    output logic              done,
    output logic              mem_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    if (ADDR_W == 0 || ADDR_W > 32) begin : g_bad_addr_w
        $error("ADDR_W must be in 1..32");
    end

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [31:0]       target_q, target_d;
    logic              pc_src_q, pc_src_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    logic is_mem;
    logic misaligned;

    assign is_mem     = mem_read | mem_write;
    assign misaligned = alu_result[1:0] != 2'b00;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        target_d   = target_q;
        pc_src_d   = pc_src_q;
        err_d      = err_q;
        done_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (stage == 3'd3) begin
                    target_d = pc_plus4 + {branch_value[29:0], 2'b00};
                    pc_src_d = branch & zero;
                    err_d    = 1'b0;
                    if ((mem_read & mem_write) || (is_mem && misaligned)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StHold;
                    end else if (is_mem) begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = alu_result[ADDR_W-1:0];
                        wdata_d = store_data;
                        state_d = StWait;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StWait: begin
                // Ack wins over a timeout expiring on the same edge.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StHold;
                    if (!we_q) begin
                        mem_data_d = dmem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StHold: begin
                // Wait for the sequencer to leave stage 3 so one stage means one capture.
                if (stage != 3'd3) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_data_q <= '0;
            target_q   <= '0;
            pc_src_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
            target_q   <= target_d;
            pc_src_q   <= pc_src_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_data      = mem_data_q;
    assign branch_target = target_q;
    assign pc_src        = pc_src_q;
    assign done          = done_q;
    assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected results, monitor checks on done.
module tb_mem_access_stage;

    localparam int TbTimeout = 4;

    logic        clock, reset;
    logic [2:0]  stage;
    logic [31:0] alu_result, branch_value, store_data, pc_plus4;
    logic        zero, mem_read, mem_write, branch;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] mem_data, branch_target;
    logic        pc_src, done, mem_err;

    mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(TbTimeout)) dut (
        .clock(clock), .reset(reset), .stage(stage), .alu_result(alu_result), .zero(zero),
        .branch_value(branch_value), .store_data(store_data), .pc_plus4(pc_plus4),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_data(mem_data), .branch_target(branch_target), .pc_src(pc_src),
        .done(done), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] target;
        logic        pc_src;
        logic        err;
        int          req_cycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          done_count = 0, req_seen = 0;
    int          ack_delay = 1;
    logic [31:0] rd_value = 0;
    logic        force_ack = 0;
    logic [31:0] model_mem = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory responder: ack in the ack_delay-th cycle of a request (0 = never).
    initial begin
        int rcnt;
        rcnt = 0;
        dmem_ack = 0;
        dmem_rdata = 0;
        forever begin
            @(negedge clock);
            if (force_ack) begin
                force_ack = 0;
                dmem_ack = 1;
                dmem_rdata = 32'hBAD0_BAD0;
                @(posedge clock);
                #1 dmem_ack = 0;
            end else if (dmem_req && !reset) begin
                rcnt++;
                if (ack_delay != 0 && rcnt == ack_delay) begin
                    dmem_ack = 1;
                    dmem_rdata = rd_value;
                    @(posedge clock);
                    #1 dmem_ack = 0;
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: checks request fields while req is up and the full result on each done pulse.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (dmem_req) begin
                    if (exp_q.size() == 0) begin
                        check1("unexpected_req", dmem_req, 1'b0);
                    end else begin
                        req_seen++;
                        check1("req_we", dmem_we, exp_q[0].we);
                        check32("req_addr", dmem_addr, exp_q[0].addr);
                        check32("req_wdata", dmem_wdata, exp_q[0].wdata);
                    end
                end
                if (done) begin
                    done_count++;
                    if (prev_done) check1("done_two_cycles", done, 1'b0);
                    if (exp_q.size() == 0) begin
                        check1("unexpected_done", done, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check32("mem_data", mem_data, e.mem_data);
                        check32("branch_target", branch_target, e.target);
                        check1("pc_src", pc_src, e.pc_src);
                        check1("mem_err", mem_err, e.err);
                        check32("req_cycles", 32'(req_seen), 32'(e.req_cycles));
                        check1("req_low_at_done", dmem_req, 1'b0);
                    end
                    req_seen = 0;
                end
            end
            prev_done = done;
        end
    end

    task automatic scramble_inputs();
        logic [31:0] r;
        r = $urandom;
        alu_result = $urandom;
        store_data = $urandom;
        pc_plus4 = $urandom;
        branch_value = $urandom;
        mem_read = r[0];
        mem_write = r[1];
        branch = r[2];
        zero = r[3];
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic br, input logic z,
                         input logic [31:0] alu, input logic [31:0] bv, input logic [31:0] sd,
                         input logic [31:0] pc4, input int delay, input logic [31:0] rdata,
                         input int hold);
        exp_t e;
        int start, n;
        logic [31:0] r;
        e.target = pc4 + bv * 4;
        e.pc_src = br & z;
        e.err = (rd & wr) | ((rd | wr) & (alu % 4 != 0));
        e.mem_data = model_mem;
        e.req_cycles = 0;
        e.we = wr;
        e.addr = alu;
        e.wdata = sd;
        if (!e.err && (rd | wr)) begin
            if (delay == 0) begin
                e.err = 1;
                e.req_cycles = TbTimeout;
            end else begin
                e.req_cycles = delay;
                if (rd) e.mem_data = rdata;
            end
        end
        model_mem = e.mem_data;
        exp_q.push_back(e);
        ack_delay = delay;
        rd_value = rdata;
        @(posedge clock);
        #1;
        stage = 3'd3;
        mem_read = rd;
        mem_write = wr;
        branch = br;
        zero = z;
        alu_result = alu;
        branch_value = bv;
        store_data = sd;
        pc_plus4 = pc4;
        start = done_count;
        n = 0;
        @(posedge clock);
        #1;
        while (done_count == start && n < 60) begin
            scramble_inputs();
            @(posedge clock);
            #1;
            n++;
        end
        if (done_count == start) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
            exp_q.delete();
            req_seen = 0;
        end
        repeat (hold) begin
            scramble_inputs();
            @(posedge clock);
            #1;
        end
        r = $urandom;
        stage = (r[2:0] == 3'd3) ? 3'd4 : r[2:0];
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_req"}, dmem_req, 1'b0);
        check1({tag, "_we"}, dmem_we, 1'b0);
        check32({tag, "_addr"}, dmem_addr, 32'h0);
        check32({tag, "_wdata"}, dmem_wdata, 32'h0);
        check32({tag, "_mem_data"}, mem_data, 32'h0);
        check32({tag, "_target"}, branch_target, 32'h0);
        check1({tag, "_pc_src"}, pc_src, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, mem_err, 1'b0);
    endtask

    task automatic reset_mid_wait();
        exp_t e;
        e.target = 0;
        e.pc_src = 0;
        e.err = 0;
        e.mem_data = 0;
        e.req_cycles = 0;
        e.we = 0;
        e.addr = 32'h200;
        e.wdata = 32'h0;
        exp_q.push_back(e);
        ack_delay = 0;
        @(posedge clock);
        #1;
        stage = 3'd3;
        mem_read = 1;
        mem_write = 0;
        alu_result = 32'h200;
        store_data = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check1("req_before_reset", dmem_req, 1'b1);
        #3 reset = 1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        req_seen = 0;
        model_mem = 0;
        stage = 3'd0;
        force_ack = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        force_ack = 1;
        repeat (4) @(posedge clock);
        #1;
        check_all_zero("late_ack");
    endtask

    initial begin
        logic [31:0] r;
        logic        rd, wr;
        logic [31:0] alu;
        reset = 1;
        stage = 0;
        alu_result = 0;
        branch_value = 0;
        store_data = 0;
        pc_plus4 = 0;
        zero = 0;
        mem_read = 0;
        mem_write = 0;
        branch = 0;
        #2;
        check_all_zero("reset_state");
        repeat (2) @(posedge clock);
        #1 reset = 0;

        do_op(1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 2, 32'hDEAD_BEEF, 0);
        do_op(0, 1, 0, 0, 32'h80, 32'h0, 32'h1234_5678, 32'h0, 1, 32'hFFFF_0000, 0);
        do_op(0, 0, 1, 1, 32'h0, 32'h4, 32'h0, 32'h100, 1, 32'h0, 0);
        do_op(0, 0, 1, 1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h100, 1, 32'h0, 0);
        do_op(0, 0, 1, 0, 32'h0, 32'h4, 32'h0, 32'h100, 1, 32'h0, 0);
        do_op(1, 0, 0, 0, 32'h42, 32'h0, 32'h0, 32'h0, 1, 32'h0, 0);
        do_op(1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 1, 32'h0, 0);
        do_op(0, 0, 1, 1, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFF0, 1, 32'h0, 0);
        do_op(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h0, 1, 32'hCAFE_F00D, 5);
        do_op(1, 0, 0, 0, 32'h48, 32'h0, 32'h0, 32'h0, 3, 32'h0BAD_CAFE, 5);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            alu = $urandom & 32'hFFFF_FFFC;
            rd = 0;
            wr = 0;
            case (r[2:0] % 6)
                3'd0: rd = 1;
                3'd1: wr = 1;
                3'd2: ;
                3'd3: begin rd = 1; alu = alu | {30'b0, (r[4:3] == 0) ? 2'b01 : r[4:3]}; end
                3'd4: begin wr = 1; alu = alu | 32'h2; end
                default: begin rd = 1; wr = 1; end
            endcase
            do_op(rd, wr, r[8], r[9], alu, $urandom, $urandom, $urandom,
                  1 + int'(r[11:10]), $urandom, int'(r[13:12]));
        end

`ifdef MEM_TIMEOUT_EN
        do_op(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);
        do_op(0, 1, 1, 1, 32'h104, 32'h1, 32'h5555_AAAA, 32'h10, 0, 32'h0, 0);
`endif

        reset_mid_wait();
        do_op(1, 0, 0, 0, 32'h10, 32'h2, 32'h0, 32'h20, 1, 32'h1357_9BDF, 0);
        do_op(0, 1, 0, 0, 32'h14, 32'h0, 32'h2468_ACE0, 32'h0, 4, 32'h0, 0);

        repeat (3) @(posedge clock);
        #1;
        check32("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Stage-3 (memory) block of the multi-cycle MIPS datapath. Sits directly downstream of the ALU.
- Consumes the ALU result, zero flag and sign-extended branch offset. Performs load/store to data memory over a req/ack handshake.
- Resolves branch target and branch-taken. Produces load data and a one-cycle `done` pulse for the stage sequencer.

Parameters:
- ADDR_W, 32, width of the data-memory address driven on dmem_addr (low ADDR_W bits of the ALU result).
- TIMEOUT_CYCLES, 16, cycles to wait for dmem_ack before aborting (used only with MEM_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stage  in  3  current datapath stage; this block acts only when stage == 3.
- alu_result  in  32  ALU result; the memory address for lw/sw.
- zero  in  1  ALU zero flag.
- branch_value  in  32  sign-extended branch offset, in words.
- store_data  in  32  register read_data2, the data to store for sw.
- pc_plus4  in  32  PC+4 of the current instruction.
- mem_read  in  1  instruction is lw.
- mem_write  in  1  instruction is sw.
- branch  in  1  instruction is beq.
- dmem_req  out  1  memory request; held high until ack.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  memory byte address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data; valid in the cycle dmem_ack is high.
- dmem_ack  in  1  memory completion; single-cycle pulse.
- mem_data  out  32  captured load data.
- branch_target  out  32  computed branch target.
- pc_src  out  1  1 = branch taken.
- done  out  1  one-cycle pulse: stage complete.
- mem_err  out  1  sticky error flag for the current instruction.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0.
  - mem_data = 0, branch_target = 0, pc_src = 0, done = 0, mem_err = 0.
  - Reset during WAIT drops dmem_req in the same instant; any later ack is ignored.
- All other outputs are registered on the rising edge of clock.
- States: IDLE, WAIT, HOLD.
- IDLE, on an edge with stage == 3 (call it edge N):
  - Latch branch_target = pc_plus4 + (branch_value << 2). Arithmetic is 32-bit modulo; overflow wraps, no flag.
  - Latch pc_src = branch & zero.
  - Clear mem_err.
  - If mem_read & mem_write: mem_err = 1, done = 1, go to HOLD. No request is issued.
  - Else if (mem_read | mem_write) and alu_result[1:0] != 0: mem_err = 1, done = 1, go to HOLD. No request is issued.
  - Else if mem_read | mem_write:
    - dmem_req = 1, dmem_we = mem_write.
    - dmem_addr = alu_result[ADDR_W-1:0], dmem_wdata = store_data.
    - Go to WAIT.
  - Else (no memory op): done = 1, go to HOLD. Total latency 1 edge.
- WAIT, on each edge:
  - If dmem_ack: dmem_req = 0; done = 1; go to HOLD.
  - On ack for a read, mem_data = dmem_rdata. On ack for a write, mem_data is unchanged.
  - Otherwise dmem_req stays 1. Address, data and we are held stable.
  - Changes on stage or the control inputs are ignored while in WAIT.
- HOLD:
  - done = 0 on the next edge; done is never high for two consecutive cycles.
  - Stay in HOLD while stage == 3; go to IDLE when stage != 3. This prevents re-triggering within one stage.
- Ack handling outside WAIT: a dmem_ack in IDLE or HOLD is ignored.
- Load latency: request visible after edge N, ack sampled at edge N+k → mem_data and done visible after edge N+k. With ack in the first WAIT cycle, k = 1.
- Output holding:
  - mem_data, branch_target and pc_src hold their values until the next IDLE capture.
  - mem_err holds until the next capture.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments on each WAIT edge without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req = 0, mem_err = 1, done = 1, go to HOLD. mem_data is unchanged.
  - Ack has priority if it arrives on the same edge as expiry.
- MEM_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely until ack or reset.

Test Plan:
- lw: alu_result=0x40, mem_read=1, stage=3; ack 2 cycles after req with rdata=0xDEADBEEF → dmem_req high 2 cycles, dmem_we=0, dmem_addr=0x40, mem_data=0xDEADBEEF, done high exactly 1 cycle, mem_err=0.
- sw: alu_result=0x80, store_data=0x12345678, mem_write=1; immediate ack → dmem_we=1, dmem_wdata=0x12345678, mem_data unchanged, single done pulse.
- beq: branch=1, zero=1, pc_plus4=0x100, branch_value=4 → branch_target=0x110, pc_src=1, done after 1 edge, no dmem_req. Repeat with branch_value=0xFFFFFFFF → target 0xFC. Repeat with zero=0 → pc_src=0.
- Errors:
  - lw with alu_result=0x42 → mem_err=1, done pulse, dmem_req never asserted.
  - mem_read=mem_write=1 → same response.
- Hold stage=3 for 5 cycles after done → exactly one done pulse, no second request. Drop stage then raise it again → new capture.
- Reset asserted mid-WAIT → dmem_req=0 without waiting for a clock edge; all outputs 0; a late ack is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4 and ack never sent → mem_err=1, done after 4 WAIT edges, dmem_req dropped.
